// File: rtl/fram_i2c_target.sv
// I2C FRAM-style target: 256 x 8 register memory behind a 7-bit address 1010_A2A1A0.
// SCL/SDA are synchronized and glitch-filtered; protocol decoding uses only filtered levels.
// Optional feature macro: FRAM_TARGET_WRITE_PROTECT_EN adds a wp input that blocks memory commits.
module fram_i2c_target #(
   parameter logic [2:0] DEV_ADDR   = 3'b000,
   parameter int         FILTER_LEN = 3,
   parameter logic [7:0] INIT_FILL  = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
`ifdef FRAM_TARGET_WRITE_PROTECT_EN
   input  logic       wp,
`endif
   output logic       sda_o,
   output logic       sda_t,
   output logic       busy,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_WORD_ADDR, S_WORD_ACK,
      S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
   } state_t;

   logic          r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
   logic          r_scl_f, r_sda_f, r_scl_q, r_sda_q;
   logic [CW-1:0] r_scl_cnt, r_sda_cnt;
   state_t        r_state;
   logic [3:0]    r_bitcnt;
   logic [7:0]    r_shift;
   logic [7:0]    r_ptr;
   logic          r_rw;
   logic          r_mack;
   logic [7:0]    r_mem [256];

   logic w_scl_rise, w_scl_fall, w_start, w_stop;
   logic w_rx_state, w_rx_shift, w_byte_done;

   assign sda_o = 1'b0;

   assign w_scl_rise  = r_scl_f & ~r_scl_q;
   assign w_scl_fall  = ~r_scl_f & r_scl_q;
   assign w_start     = r_scl_f & r_scl_q & r_sda_q & ~r_sda_f;
   assign w_stop      = r_scl_f & r_scl_q & ~r_sda_q & r_sda_f;
   assign w_rx_state  = (r_state == S_DEV_ADDR) || (r_state == S_WORD_ADDR) || (r_state == S_WR_DATA);
   assign w_rx_shift  = w_scl_rise & (r_bitcnt != 4'd8);
   assign w_byte_done = w_scl_fall & (r_bitcnt == 4'd8);

   // Two-flop synchronizers, FILTER_LEN-sample glitch filters, and previous filtered levels for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scl_s1  <= 1'b1;
         r_scl_s2  <= 1'b1;
         r_sda_s1  <= 1'b1;
         r_sda_s2  <= 1'b1;
         r_scl_f   <= 1'b1;
         r_sda_f   <= 1'b1;
         r_scl_q   <= 1'b1;
         r_sda_q   <= 1'b1;
         r_scl_cnt <= '0;
         r_sda_cnt <= '0;
      end else begin
         r_scl_s1 <= scl_i;
         r_scl_s2 <= r_scl_s1;
         r_sda_s1 <= sda_i;
         r_sda_s2 <= r_sda_s1;
         r_scl_q  <= r_scl_f;
         r_sda_q  <= r_sda_f;
         if (r_scl_s2 == r_scl_f) begin
            r_scl_cnt <= '0;
         end else if (r_scl_cnt == CW'(FILTER_LEN - 1)) begin
            r_scl_f   <= r_scl_s2;
            r_scl_cnt <= '0;
         end else begin
            r_scl_cnt <= r_scl_cnt + 1'b1;
         end
         if (r_sda_s2 == r_sda_f) begin
            r_sda_cnt <= '0;
         end else if (r_sda_cnt == CW'(FILTER_LEN - 1)) begin
            r_sda_f   <= r_sda_s2;
            r_sda_cnt <= '0;
         end else begin
            r_sda_cnt <= r_sda_cnt + 1'b1;
         end
      end
   end

   // Protocol FSM with registered SDA drive, status outputs, address pointer and memory
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         sda_t     <= 1'b1;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         r_ptr     <= '0;
         r_bitcnt  <= '0;
         r_shift   <= '0;
         r_rw      <= 1'b0;
         r_mack    <= 1'b0;
         for (int unsigned i = 0; i < 256; i++) r_mem[i] <= INIT_FILL;
      end else begin
         wr_strobe <= 1'b0;
         if (w_stop) begin
            r_state  <= S_IDLE;
            sda_t    <= 1'b1;
            busy     <= 1'b0;
            r_bitcnt <= '0;
         end else if (w_start) begin
            r_state  <= S_DEV_ADDR;
            sda_t    <= 1'b1;
            busy     <= 1'b0;
            r_bitcnt <= '0;
         end else begin
            if (w_rx_state && w_rx_shift) begin
               r_shift  <= {r_shift[6:0], r_sda_f};
               r_bitcnt <= r_bitcnt + 4'd1;
            end
            case (r_state)
               S_DEV_ADDR: if (w_byte_done) begin
                  r_bitcnt <= '0;
                  if (r_shift[7:1] == {4'b1010, DEV_ADDR}) begin
                     r_rw    <= r_shift[0];
                     busy    <= 1'b1;
                     sda_t   <= 1'b0;
                     r_state <= S_DEV_ACK;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
               S_DEV_ACK: if (w_scl_fall) begin
                  if (r_rw) begin
                     r_shift <= r_mem[r_ptr];
                     sda_t   <= r_mem[r_ptr][7];
                     r_state <= S_RD_DATA;
                  end else begin
                     sda_t   <= 1'b1;
                     r_state <= S_WORD_ADDR;
                  end
               end
               S_WORD_ADDR: if (w_byte_done) begin
                  r_bitcnt <= '0;
                  r_ptr    <= r_shift;
                  sda_t    <= 1'b0;
                  r_state  <= S_WORD_ACK;
               end
               S_WORD_ACK: if (w_scl_fall) begin
                  sda_t   <= 1'b1;
                  r_state <= S_WR_DATA;
               end
               S_WR_DATA: if (w_byte_done) begin
                  r_bitcnt <= '0;
                  sda_t    <= 1'b0;
                  r_state  <= S_WR_ACK;
               end
               S_WR_ACK: if (w_scl_fall) begin
`ifdef FRAM_TARGET_WRITE_PROTECT_EN
                  if (!wp) begin
                     r_mem[r_ptr] <= r_shift;
                     wr_strobe    <= 1'b1;
                     wr_addr      <= r_ptr;
                     wr_data      <= r_shift;
                  end
`else
                  r_mem[r_ptr] <= r_shift;
                  wr_strobe    <= 1'b1;
                  wr_addr      <= r_ptr;
                  wr_data      <= r_shift;
`endif
                  r_ptr   <= r_ptr + 8'd1;
                  sda_t   <= 1'b1;
                  r_state <= S_WR_DATA;
               end
               // Read byte is latched at byte start so the pointer can advance after bit 8
               S_RD_DATA: begin
                  if (w_scl_rise) begin
                     r_bitcnt <= r_bitcnt + 4'd1;
                     if (r_bitcnt == 4'd7) r_ptr <= r_ptr + 8'd1;
                  end else if (w_scl_fall) begin
                     if (r_bitcnt == 4'd8) begin
                        r_bitcnt <= '0;
                        sda_t    <= 1'b1;
                        r_state  <= S_RD_ACK;
                     end else begin
                        sda_t   <= r_shift[6];
                        r_shift <= {r_shift[6:0], 1'b0};
                     end
                  end
               end
               // A NACK parks in IDLE with busy held until the next STOP or START
               S_RD_ACK: begin
                  if (w_scl_rise) begin
                     r_mack <= ~r_sda_f;
                  end else if (w_scl_fall) begin
                     if (r_mack) begin
                        r_shift <= r_mem[r_ptr];
                        sda_t   <= r_mem[r_ptr][7];
                        r_state <= S_RD_DATA;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fram_i2c_target.sv
// Directed bench for fram_i2c_target: bit-banged I2C controller on an open-drain SDA bus.
// Define FRAM_TARGET_WRITE_PROTECT_EN to also exercise the wp input.
module tb_fram_i2c_target;

   localparam int Q = 10;   // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic       w_sda;
   logic       sda_o, sda_t, busy, wr_strobe;
   logic [7:0] wr_addr, wr_data;
`ifdef FRAM_TARGET_WRITE_PROTECT_EN
   logic       wp = 1'b0;
`endif

   int errors = 0;
   int checks = 0;
   int strobe_cnt = 0;
   int low_cnt = 0;

   assign w_sda = sda_m & sda_t;

   fram_i2c_target #(.DEV_ADDR(3'b000), .FILTER_LEN(3), .INIT_FILL(8'h00)) dut (
      .clk(clk), .rst(rst), .scl_i(scl), .sda_i(w_sda),
`ifdef FRAM_TARGET_WRITE_PROTECT_EN
      .wp(wp),
`endif
      .sda_o(sda_o), .sda_t(sda_t), .busy(busy), .wr_strobe(wr_strobe),
      .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   // Count commit pulses and cycles in which the target pulls SDA low
   always @(posedge clk) begin
      if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
      if (!sda_t)    low_cnt    <= low_cnt + 1;
   end

   typedef struct {
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wq(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq(Q);
      scl = 1'b1;   wq(Q);
      sda_m = 1'b0; wq(Q);
      scl = 1'b0;   wq(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq(Q);
      scl = 1'b1;   wq(Q);
      sda_m = 1'b1; wq(Q);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sda_m = b[i]; wq(Q);
         scl = 1'b1;   wq(2 * Q);
         scl = 1'b0;   wq(Q);
      end
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      sda_m = 1'b1; wq(Q);
      scl = 1'b1;   wq(Q);
      ack = ~w_sda; wq(Q);
      scl = 1'b0;   wq(Q);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; wq(Q);
         scl = 1'b1;   wq(Q);
         b[i] = w_sda; wq(Q);
         scl = 1'b0;   wq(Q);
      end
      sda_m = ~mack; wq(Q);
      scl = 1'b1;    wq(2 * Q);
      scl = 1'b0;    wq(Q);
      sda_m = 1'b1;
   endtask

   initial begin
      vec_t       tv [4];
      logic       ack;
      logic [7:0] rd;
      int         sc0, lc0;

      tv[0] = '{addr: 8'h04, wdata: 8'hA5, exp_rd: 8'hA5};
      tv[1] = '{addr: 8'h55, wdata: 8'h3C, exp_rd: 8'h3C};
      tv[2] = '{addr: 8'h80, wdata: 8'hC3, exp_rd: 8'hC3};
      tv[3] = '{addr: 8'h7F, wdata: 8'h81, exp_rd: 8'h81};

      // Reset state
      wq(5);
      chk("rst_sda_t", sda_t, 1);
      chk("rst_sda_o", sda_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_strobe", wr_strobe, 0);
      chk("rst_wr_addr", wr_addr, 8'h00);
      chk("rst_wr_data", wr_data, 8'h00);
      rst = 1'b1;
      wq(2 * Q);

      // Table: single-byte write, then random read of the same location
      for (int v = 0; v < 4; v++) begin
         sc0 = strobe_cnt;
         i2c_start();
         write_byte(8'hA0, ack);  chk("wr_dev_ack", ack, 1);
         chk("busy_after_match", busy, 1);
         write_byte(tv[v].addr, ack);  chk("wr_word_ack", ack, 1);
         write_byte(tv[v].wdata, ack); chk("wr_data_ack", ack, 1);
         i2c_stop();
         wq(Q);
         chk("wr_strobe_count", strobe_cnt - sc0, 1);
         chk("wr_addr", wr_addr, tv[v].addr);
         chk("wr_data", wr_data, tv[v].wdata);
         chk("busy_after_stop", busy, 0);
         i2c_start();
         write_byte(8'hA0, ack);  chk("rd_dev_ack", ack, 1);
         write_byte(tv[v].addr, ack); chk("rd_word_ack", ack, 1);
         i2c_start();
         write_byte(8'hA1, ack);  chk("rd_devr_ack", ack, 1);
         read_byte(1'b0, rd);
         chk("rd_data", rd, tv[v].exp_rd);
         i2c_stop();
         wq(Q);
         chk("rd_busy_after_stop", busy, 0);
      end

      // Non-matching device address: no ACK, no drive, not busy
      sc0 = strobe_cnt;
      lc0 = low_cnt;
      i2c_start();
      write_byte(8'hA2, ack);  chk("bad_addr_nack", ack, 0);
      chk("bad_addr_busy", busy, 0);
      write_byte(8'h04, ack);  chk("bad_addr_ignored", ack, 0);
      i2c_stop();
      wq(Q);
      chk("bad_addr_no_drive", low_cnt - lc0, 0);
      chk("bad_addr_no_write", strobe_cnt - sc0, 0);

      // Pointer wrap on write and on sequential read
      sc0 = strobe_cnt;
      i2c_start();
      write_byte(8'hA0, ack); chk("wrap_dev_ack", ack, 1);
      write_byte(8'hFF, ack); chk("wrap_word_ack", ack, 1);
      write_byte(8'h11, ack); chk("wrap_d0_ack", ack, 1);
      write_byte(8'h22, ack); chk("wrap_d1_ack", ack, 1);
      i2c_stop();
      wq(Q);
      chk("wrap_strobes", strobe_cnt - sc0, 2);
      chk("wrap_wr_addr", wr_addr, 8'h00);
      chk("wrap_wr_data", wr_data, 8'h22);
      i2c_start();
      write_byte(8'hA0, ack); write_byte(8'hFF, ack);
      i2c_start();
      write_byte(8'hA1, ack); chk("wrap_rd_ack", ack, 1);
      read_byte(1'b1, rd);    chk("wrap_rd0", rd, 8'h11);
      read_byte(1'b0, rd);    chk("wrap_rd1", rd, 8'h22);
      i2c_stop();
      wq(Q);

      // STOP after 4 data bits: partial byte is discarded
      sc0 = strobe_cnt;
      i2c_start();
      write_byte(8'hA0, ack); write_byte(8'h40, ack);
      send_bits(8'hB0, 4);
      i2c_stop();
      wq(Q);
      chk("partial_no_strobe", strobe_cnt - sc0, 0);
      chk("partial_busy", busy, 0);
      chk("partial_sda_t", sda_t, 1);
      i2c_start();
      write_byte(8'hA0, ack); write_byte(8'h40, ack);
      i2c_start();
      write_byte(8'hA1, ack); read_byte(1'b0, rd);
      chk("partial_mem_untouched", rd, 8'h00);
      i2c_stop();
      wq(Q);

`ifdef FRAM_TARGET_WRITE_PROTECT_EN
      // Write-protected byte is ACKed but not committed
      sc0 = strobe_cnt;
      wp = 1'b1;
      i2c_start();
      write_byte(8'hA0, ack); write_byte(8'h10, ack);
      write_byte(8'h5A, ack); chk("wp_data_ack", ack, 1);
      i2c_stop();
      wq(Q);
      wp = 1'b0;
      chk("wp_no_strobe", strobe_cnt - sc0, 0);
      i2c_start();
      write_byte(8'hA0, ack); write_byte(8'h10, ack);
      i2c_start();
      write_byte(8'hA1, ack); read_byte(1'b0, rd);
      chk("wp_mem_unchanged", rd, 8'h00);
      i2c_stop();
      wq(Q);
`endif

      // Reset mid-read releases SDA immediately and clears the pointer
      i2c_start();
      write_byte(8'hA0, ack); write_byte(8'h30, ack); write_byte(8'h0F, ack);
      i2c_start();
      write_byte(8'hA1, ack); chk("mid_rd_ack", ack, 1);
      chk("mid_rd_drive_low", sda_t, 0);
      rst = 1'b0;
      #1;
      chk("mid_rd_rst_sda_t", sda_t, 1);
      chk("mid_rd_rst_busy", busy, 0);
      chk("mid_rd_rst_ptr", dut.r_ptr, 8'h00);
      chk("mid_rd_rst_wr_addr", wr_addr, 8'h00);
      scl = 1'b1;
      sda_m = 1'b1;
      wq(Q);
      rst = 1'b1;
      wq(Q);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fram_i2c_target.md
FRAM_I2C_TARGET -- requirements
Module: fram_i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 3'b000, device-select bits A2..A1..A0 of the 7-bit target address 4'b1010_A2A1A0.
REQ-002 Parameter FILTER_LEN, default 3, number of consecutive equal synchronized samples required to accept a new SCL/SDA level.
REQ-003 Parameter INIT_FILL, default 8'h00, value of every memory byte after reset.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 scl_i  input  1  I2C clock line sampled from bus.
REQ-007 sda_i  input  1  I2C data line sampled from bus.
REQ-008 sda_o  output  1  SDA drive value; constant 0.
REQ-009 sda_t  output  1  SDA tristate; 1 = released, 0 = pull low.
REQ-010 busy  output  1  high from accepted START with address match until STOP or next START.
REQ-011 wr_strobe  output  1  one-cycle pulse per byte committed to memory.
REQ-012 wr_addr  output  8  memory address of last committed byte.
REQ-013 wr_data  output  8  value of last committed byte.

Function
REQ-014 scl_i and sda_i pass a 2-flop synchronizer, then the FILTER_LEN glitch filter; all decoding uses filtered levels.
REQ-015 START = filtered SDA 1->0 while SCL high; STOP = SDA 0->1 while SCL high; both are detected in any state, including mid-byte.
REQ-016 Data bits are sampled on filtered SCL rising edge, MSB first; target drives SDA only after SCL falling edge.
REQ-017 States: IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-018 IDLE -> DEV_ADDR on START; STOP in any state -> IDLE with sda_t=1 and busy=0.
REQ-019 DEV_ADDR: after 8 bits, match of bits[7:1] to {4'b1010,DEV_ADDR} -> DEV_ACK; mismatch -> IDLE without ACK (sda_t stays 1).
REQ-020 ACK: sda_t=0 from SCL falling edge after bit 8 until SCL falling edge after bit 9.
REQ-021 DEV_ACK: R/W=0 -> WORD_ADDR; R/W=1 -> RD_DATA starting at the current address pointer.
REQ-022 WORD_ADDR: 8 bits loaded into the address pointer, ACKed, -> WR_DATA.
REQ-023 WR_DATA: each received byte written to mem[pointer] at SCL falling edge after bit 9, wr_strobe pulses, wr_addr/wr_data update, pointer increments, ACKed.
REQ-024 RD_DATA: mem[pointer] shifted out MSB first (bit 0 -> sda_t=0, bit 1 -> sda_t=1); pointer increments after bit 8.
REQ-025 RD_ACK: controller ACK (SDA low at 9th SCL rise) -> RD_DATA next byte; NACK -> wait for STOP/START, SDA released.
REQ-026 Pointer is 8 bits, wraps 8'hFF -> 8'h00 in both write and read.
REQ-027 Repeated START in any state returns to DEV_ADDR; pointer retained (supports address-set then random read).
REQ-028 A START/STOP mid-byte discards the partial byte; no memory write.
REQ-029 Memory: 256 x 8, register-based, read combinationally by the shift logic.

Reset
REQ-030 While rst=0: state IDLE, sda_t=1, sda_o=0, busy=0, wr_strobe=0, wr_addr=8'h00, wr_data=8'h00, pointer=8'h00, bit counter 0, filters preset to 1, memory = INIT_FILL.
REQ-031 Reset asserted mid-transfer releases SDA in the same cycle (asynchronous).

Configuration
REQ-032 Macro FRAM_TARGET_WRITE_PROTECT_EN defined: extra port wp input 1; when wp=1 in WR_DATA, bytes are ACKed and pointer increments but memory unchanged and wr_strobe stays 0.
REQ-033 Macro undefined: no wp port; all writes commit.

Verification
REQ-034 Write 0xA0,0x04,0xA5,STOP -> ACK on all three bytes, wr_strobe once, wr_addr=0x04, wr_data=0xA5, mem[0x04]=0xA5.
REQ-035 Random read: 0xA0,0x04, repeated START, 0xA1, read 1 byte, NACK, STOP -> SDA returns 0xA5, busy low after STOP.
REQ-036 Address 0xA2 (DEV_ADDR=000) -> no ACK, sda_t=1 throughout, busy=0, memory unchanged.
REQ-037 Write at 0xFF bytes 0x11,0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22; sequential read from 0xFF with ACK returns 0x11,0x22.
REQ-038 STOP after 4 bits of a data byte -> state IDLE, no wr_strobe; rst pulsed low mid-read -> sda_t=1 immediately, pointer=0x00.
REQ-039 With FRAM_TARGET_WRITE_PROTECT_EN, wp=1, write 0x5A at 0x10 -> ACKed, mem[0x10] stays INIT_FILL, wr_strobe=0.
